// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide
// sequencer (op encoding, FSM states, ALU control codes, negate/abs helpers).
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  // Operation encoding presented on op
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Shared ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Two's-complement negate of a 32-bit value
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Two's-complement negate of a 64-bit value
  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Conditional absolute value: negate when the recorded sign is set
  function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic neg);
    return neg ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: 35-cycle iterative MULT/MULTU/DIV/DIVU sequencer that time-shares
// the EX-stage ALU and owns the HI/LO registers (including MTHI/MTLO writes).
// Optional feature macro: MULDIV_SIGNED_EN enables signed MULT/DIV; when it is
// undefined op[1] is ignored and MULT/DIV behave as MULTU/DIVU.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  state_e      r_state;
  state_e      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc_hi;   // P_hi[31:0] for multiply, remainder R for divide
  logic [31:0] r_acc_lo;   // P_lo for multiply, quotient Q for divide
  logic [31:0] r_opnd;     // multiplicand or divisor (magnitude)
  logic [1:0]  r_op;
  logic        r_neg_a;
  logic        r_neg_b;
  logic        r_dz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [3:0]  w_alu_ctrl;
  logic [32:0] w_rem_sh;
  logic        w_carry;
  logic        w_sub_ok;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [63:0] w_prod;
  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;
  logic        w_dz_res;

  // Shifted remainder and per-iteration decisions for both algorithms
  assign w_rem_sh = {r_acc_hi, r_acc_lo[31]};
  assign w_carry  = (alu_result < w_alu_a);
  assign w_sub_ok = w_rem_sh[32] | (w_rem_sh[31:0] >= r_opnd);

  // Sign capture in PREP: raw rs is parked in r_acc_hi, raw rt in r_acc_lo
  assign w_neg_a = SIGNED_EN & r_op[1] & r_acc_hi[31];
  assign w_neg_b = SIGNED_EN & r_op[1] & r_acc_lo[31];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and shared-ALU drive (ALU is only borrowed during ITER)
  always_comb begin
    w_state_nxt = r_state;
    w_alu_a     = 32'd0;
    w_alu_b     = 32'd0;
    w_alu_ctrl  = ALU_AND;
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = start ? ST_PREP : ST_IDLE;
        ST_PREP:  w_state_nxt = ST_ITER;
        ST_ITER:  w_state_nxt = (r_cnt == 5'd0) ? ST_FIXUP : ST_ITER;
        ST_FIXUP: w_state_nxt = ST_DONE;
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
    if (r_state == ST_ITER) begin
      if (r_op[0]) begin
        w_alu_ctrl = ALU_SUB;
        w_alu_a    = w_rem_sh[31:0];
        w_alu_b    = r_opnd;
      end else begin
        w_alu_ctrl = ALU_ADD;
        w_alu_a    = r_acc_hi;
        w_alu_b    = r_acc_lo[0] ? r_opnd : 32'd0;
      end
    end else begin
      w_alu_ctrl = ALU_AND;
    end
  end

  // Result fixup: sign correction and divide-by-zero override
  always_comb begin
    w_prod   = {r_acc_hi, r_acc_lo};
    w_hi_res = r_acc_hi;
    w_lo_res = r_acc_lo;
    w_dz_res = 1'b0;
    if (r_op[0]) begin
      if (r_opnd == 32'd0) begin
        // Remainder equals |rs|; restoring the sign returns the raw rs_val
        w_hi_res = cond_neg32(r_acc_hi, r_neg_a);
        w_lo_res = 32'hFFFF_FFFF;
        w_dz_res = 1'b1;
      end else begin
        w_hi_res = cond_neg32(r_acc_hi, r_neg_a);
        w_lo_res = cond_neg32(r_acc_lo, r_neg_a ^ r_neg_b);
      end
    end else begin
      if (r_neg_a ^ r_neg_b) begin
        w_prod = neg64({r_acc_hi, r_acc_lo});
      end else begin
        w_prod = {r_acc_hi, r_acc_lo};
      end
      w_hi_res = w_prod[63:32];
      w_lo_res = w_prod[31:0];
    end
  end

  // Datapath: operand capture, iteration, commit and MTHI/MTLO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 5'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_opnd   <= 32'd0;
      r_op     <= 2'b00;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc_hi <= rs_val;
            r_acc_lo <= rt_val;
            r_op     <= op;
            r_dz     <= 1'b0;
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        ST_PREP: begin
          r_neg_a  <= w_neg_a;
          r_neg_b  <= w_neg_b;
          r_acc_hi <= 32'd0;
          r_cnt    <= 5'd31;
          if (r_op[0]) begin
            r_opnd   <= cond_neg32(r_acc_lo, w_neg_b);
            r_acc_lo <= cond_neg32(r_acc_hi, w_neg_a);
          end else begin
            r_opnd   <= cond_neg32(r_acc_hi, w_neg_a);
            r_acc_lo <= cond_neg32(r_acc_lo, w_neg_b);
          end
        end
        ST_ITER: begin
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
          if (r_op[0]) begin
            r_acc_hi <= w_sub_ok ? alu_result : w_rem_sh[31:0];
            r_acc_lo <= {r_acc_lo[30:0], w_sub_ok};
          end else begin
            r_acc_hi <= {w_carry, alu_result[31:1]};
            r_acc_lo <= {alu_result[0], r_acc_lo[31:1]};
          end
        end
        ST_FIXUP: begin
          if (!abort) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
            r_dz <= w_dz_res;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign alu_a    = w_alu_a;
  assign alu_b    = w_alu_b;
  assign alu_ctrl = w_alu_ctrl;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign dz       = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq with a behavioural
// model of the shared EX-stage ALU. Expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        abort;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .abort(abort),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  // External ALU model
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = alu_a & alu_b;
    endcase
  end

  // Launch an op: start is sampled at edge 0; returns at the negedge of cycle 1
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, starting at the negedge of cycle c0
  task automatic wait_done(input int c0, output int dc);
    dc = -1;
    for (int c = c0; c <= 40 && dc < 0; c++) begin
      if (c > c0) @(negedge clk);
      if (done) dc = c;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input bit chk_alu, input string nm);
    int dc;
    logic [3:0] ea;
    issue(o, a, b);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_c1 got %0b want 1", nm, busy); end
    dc = -1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (chk_alu) begin
        ea = (c >= 2 && c <= 33) ? 4'b0010 : 4'b0000;
        n_cmp++;
        if (alu_ctrl !== ea) begin
          n_err++; $display("FAIL %s alu_ctrl_c%0d got %b want %b", nm, c, alu_ctrl, ea);
        end
      end
      if (done) dc = c;
    end
    n_cmp++;
    if (dc != 35) begin n_err++; $display("FAIL %s done_cycle got %0d want 35", nm, dc); end
    n_cmp++;
    if (hi !== eh) begin n_err++; $display("FAIL %s hi got %h want %h", nm, hi, eh); end
    n_cmp++;
    if (lo !== el) begin n_err++; $display("FAIL %s lo got %h want %h", nm, lo, el); end
    n_cmp++;
    if (dz !== edz) begin n_err++; $display("FAIL %s dz got %0b want %0b", nm, dz, edz); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL %s idle_c36 got busy=%0b done=%0b want 0/0", nm, busy, done);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy, done, dz} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b want 000", {busy, done, dz});
    end
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_err++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo);
    end
    n_cmp++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'd0) begin
      n_err++; $display("FAIL reset_alu got %h/%h/%h want 0", alu_a, alu_b, alu_ctrl);
    end
  endtask

  task automatic test_multu();
    run_op(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b1, "multu_7x6");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, "multu_max");
  endtask

  task automatic test_divu();
    run_op(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, "divu_100_7");
    run_op(2'b01, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0, "divu_by0");
    run_op(2'b01, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 1'b0, 1'b0, "divu_big");
  endtask

  task automatic test_signed();
`ifdef MULDIV_SIGNED_EN
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0, "mult_m3_5");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_by0");
`else
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0, 1'b0, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, 1'b0, 1'b0, "mult_m3_5");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_by0");
`endif
  endtask

  task automatic test_abort();
    int dc;
    bit saw_done;
    // Preload HI/LO through MTHI/MTLO so the abort has something to preserve
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_1111;
    @(negedge clk);
    hi_we = 1'b0; wdata = 32'h2222_2222;
    @(negedge clk);
    lo_we = 1'b0;
    n_cmp++;
    if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      n_err++; $display("FAIL abort_preload got %h/%h want 11111111/22222222", hi, lo);
    end
    issue(2'b00, 32'd9, 32'd9);
    saw_done = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    abort = 1'b1;                    // held during cycle 10
    @(negedge clk);                  // cycle 11
    abort = 1'b0;
    if (done) saw_done = 1'b1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle_c11 busy got %0b want 0", busy); end
    n_cmp++;
    if (saw_done) begin n_err++; $display("FAIL abort_no_done got 1 want 0"); end
    n_cmp++;
    if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      n_err++; $display("FAIL abort_hilo got %h/%h want 11111111/22222222", hi, lo);
    end
    // New start in cycle 11 must be accepted
    start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL abort_restart busy got %0b want 1", busy); end
    wait_done(1, dc);
    n_cmp++;
    if (dc != 35 || lo !== 32'd15 || hi !== 32'd0) begin
      n_err++; $display("FAIL abort_restart_res got cyc=%0d %h/%h want 35 0/f", dc, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    int dc;
    logic [31:0] prev_hi, prev_lo;
    prev_hi = hi;
    issue(2'b00, 32'd2, 32'd3);
    repeat (4) @(negedge clk);       // cycle 5
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);                  // cycle 6
    hi_we = 1'b0;
    n_cmp++;
    if (hi !== prev_hi) begin n_err++; $display("FAIL mthi_busy got %h want %h", hi, prev_hi); end
    wait_done(6, dc);
    n_cmp++;
    if (dc != 35 || lo !== 32'd6) begin
      n_err++; $display("FAIL mthi_busy_res got cyc=%0d lo=%h want 35 6", dc, lo);
    end
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    n_cmp++;
    if (hi !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mthi_idle got %h want a5a5a5a5", hi); end
    prev_lo = lo;
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_val = 32'd4; rt_val = 32'd4;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    n_cmp++;
    if (lo !== prev_lo) begin n_err++; $display("FAIL mtlo_with_start got %h want %h", lo, prev_lo); end
    wait_done(1, dc);
    n_cmp++;
    if (lo !== 32'd16) begin n_err++; $display("FAIL mtlo_start_res got %h want 10", lo); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 1'b0, "b2b_mul");
    run_op(2'b01, 32'd5, 32'd10, 32'd5, 32'd0, 1'b0, 1'b0, "b2b_div");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
    abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_multu();
    test_divu();
    test_signed();
    test_abort();
    test_mthi_mtlo();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
